// File: rtl/priv_status_unit.sv
// priv_status_unit: mstatus/sstatus state, current privilege, FS dirty tracking and TW WFI monitor
module priv_status_unit #(
   parameter int XLEN = 64,
   parameter bit HAS_S = 1,
   parameter bit HAS_U = 1,
   parameter bit HAS_FS = 1,
   parameter int TW_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_write,
   input  logic [XLEN-1:0] data_csr,
   input  logic            mrw_mstatus_sel,
   input  logic            srw_sstatus_sel,
   input  logic            valid,
   input  logic            m_ret,
   input  logic            s_ret,
   input  logic            trap_target_m,
   input  logic            trap_target_s,
   input  logic            fp_write,
   input  logic            wfi_exec,
   input  logic            wfi_wake,
   output logic            sie,
   output logic            mie,
   output logic            mprv,
   output logic            sum,
   output logic            mxr,
   output logic            tvm,
   output logic            tw,
   output logic            tsr,
   output logic [3:0]      priv,
   output logic [3:0]      mod_priv,
   output logic [3:0]      eff_priv,
   output logic [1:0]      fs,
   output logic            fp_enable,
   output logic            wfi_illegal,
   output logic [XLEN-1:0] mstatus,
   output logic [XLEN-1:0] sstatus
);
   localparam logic [1:0] PM = 2'b11, PS = 2'b01, PU = 2'b00;
   localparam logic [1:0] LOW = HAS_U ? PU : PM;
   localparam int CW = TW_TIMEOUT > 0 ? $clog2(TW_TIMEOUT + 1) : 1;
   typedef enum logic {IDLE, WAIT} wfi_t;
   logic [1:0] prv, mpp;
   logic spie, mpie, spp, trap_s, sret, mpp_ok, abort;
   logic [63:0] ms, ss;
   wfi_t st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   function automatic logic [3:0] onehot(input logic [1:0] p);
      return 4'b0001 << p;
   endfunction
   assign trap_s = trap_target_s & HAS_S;
   assign sret = valid & s_ret & HAS_S;
   assign mpp_ok = data_csr[12:11] == PM || (data_csr[12:11] == PS && HAS_S) || (data_csr[12:11] == PU && HAS_U);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {sie, mie, spie, mpie, spp, mprv, sum, mxr, tvm, tw, tsr} <= '0;
         mpp <= PU;
         fs <= 2'b00;
         prv <= PM;
      end else if (trap_target_m) begin
         mpie <= mie;
         mie <= 1'b0;
         mpp <= prv;
         prv <= PM;
      end else if (trap_s) begin
         spie <= sie;
         sie <= 1'b0;
         spp <= prv == PS;
         prv <= PS;
      end else if (valid && m_ret) begin
         mie <= mpie;
         mpie <= 1'b1;
         prv <= mpp;
         mpp <= LOW;
         if (mpp != PM) mprv <= 1'b0;
      end else if (sret) begin
         sie <= spie;
         spie <= 1'b1;
         prv <= (spp || !HAS_U) ? PS : PU;
         spp <= ~HAS_U;
         mprv <= 1'b0;
      end else if (csr_write && mrw_mstatus_sel) begin
         sie <= data_csr[1] & HAS_S;
         mie <= data_csr[3];
         spie <= data_csr[5] & HAS_S;
         mpie <= data_csr[7];
         spp <= data_csr[8] & HAS_S;
         if (mpp_ok) mpp <= data_csr[12:11];
         fs <= HAS_FS ? data_csr[14:13] : 2'b00;
         mprv <= data_csr[17];
         sum <= data_csr[18] & HAS_S;
         mxr <= data_csr[19];
         tvm <= data_csr[20] & HAS_S;
         tw <= data_csr[21];
         tsr <= data_csr[22] & HAS_S;
      end else if (csr_write && srw_sstatus_sel) begin
         sie <= data_csr[1] & HAS_S;
         spie <= data_csr[5] & HAS_S;
         spp <= data_csr[8] & HAS_S;
         fs <= HAS_FS ? data_csr[14:13] : 2'b00;
         sum <= data_csr[18] & HAS_S;
         mxr <= data_csr[19];
      end else if (valid && fp_write && fs != 2'b00) fs <= 2'b11;
   assign priv = onehot(prv);
   assign mod_priv = onehot(mpp);
   assign eff_priv = mprv ? onehot(mpp) : onehot(prv);
   assign fp_enable = fs != 2'b00;
   // Built at 64 bits so the XLEN=64-only fields never index out of range at XLEN=32
   always_comb begin
      ms = '0;
      ms[1] = sie;
      ms[3] = mie;
      ms[5] = spie;
      ms[7] = mpie;
      ms[8] = spp;
      ms[12:11] = mpp;
      ms[14:13] = fs;
      ms[22:17] = {tsr, tw, tvm, mxr, sum, mprv};
      ms[33:32] = (XLEN == 64 && HAS_U) ? 2'b10 : 2'b00;
      ms[35:34] = (XLEN == 64 && HAS_S) ? 2'b10 : 2'b00;
      ms[XLEN-1] = fs == 2'b11;
      ss = '0;
      ss[1] = sie;
      ss[5] = spie;
      ss[8] = spp;
      ss[14:13] = fs;
      ss[19:18] = {mxr, sum};
      ss[33:32] = ms[33:32];
      ss[XLEN-1] = ms[XLEN-1];
   end
   assign mstatus = ms[XLEN-1:0];
   assign sstatus = ss[XLEN-1:0];
   assign abort = wfi_wake | trap_target_m | trap_s | ~tw;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st <= IDLE;
         cnt <= '0;
      end else begin
         st <= st_n;
         cnt <= cnt_n;
      end
   always_comb begin
      st_n = st;
      cnt_n = cnt;
      if (st == IDLE) begin
         if (valid && wfi_exec && tw && prv != PM) begin
            st_n = WAIT;
            cnt_n = CW'(TW_TIMEOUT);
         end
      end else if (abort || cnt == '0) st_n = IDLE;
      else cnt_n = cnt - CW'(1);
   end
   always_comb wfi_illegal = st == WAIT && cnt == '0 && !abort;
endmodule

// File: tb/tb_priv_status_unit.sv
// tb_priv_status_unit: random and directed stimulus, word-level reference model, queued scoreboard
module tb_priv_status_unit;
   localparam int TW = 4;
   localparam logic [63:0] MMASK = 64'h7E_79AA, SMASK = 64'hC_6122;
   logic clk = 0, rst = 0;
   logic csr_write, mrw_mstatus_sel, srw_sstatus_sel, valid, m_ret, s_ret;
   logic trap_target_m, trap_target_s, fp_write, wfi_exec, wfi_wake;
   logic [63:0] data_csr;
   logic sie, mie, mprv, sum, mxr, tvm, tw, tsr, fp_enable, wfi_illegal;
   logic [3:0] priv, mod_priv, eff_priv;
   logic [1:0] fs;
   logic [63:0] mstatus, sstatus;
   logic n_sie, n_mie, n_mprv, n_sum, n_mxr, n_tvm, n_tw, n_tsr, n_fp_enable, n_wfi_illegal;
   logic [3:0] n_priv, n_mod_priv, n_eff_priv;
   logic [1:0] n_fs;
   logic [63:0] n_mstatus, n_sstatus;
   int nchk = 0, nerr = 0;
   typedef struct {
      string tag;
      logic [63:0] ms, ss;
      logic [3:0] priv, modp, effp;
      logic [1:0] fs;
      logic [7:0] ctrl;
      logic fpen, wi;
   } exp_t;
   exp_t q[$];
   logic [63:0] mst;
   logic [1:0] mode;
   bit wpend;
   int wdue, cyc = 0;

   priv_status_unit #(.XLEN(64), .HAS_S(1), .HAS_U(1), .HAS_FS(1), .TW_TIMEOUT(TW)) u0 (
      .clk(clk), .rst(rst), .csr_write(csr_write), .data_csr(data_csr),
      .mrw_mstatus_sel(mrw_mstatus_sel), .srw_sstatus_sel(srw_sstatus_sel), .valid(valid),
      .m_ret(m_ret), .s_ret(s_ret), .trap_target_m(trap_target_m), .trap_target_s(trap_target_s),
      .fp_write(fp_write), .wfi_exec(wfi_exec), .wfi_wake(wfi_wake),
      .sie(sie), .mie(mie), .mprv(mprv), .sum(sum), .mxr(mxr), .tvm(tvm), .tw(tw), .tsr(tsr),
      .priv(priv), .mod_priv(mod_priv), .eff_priv(eff_priv), .fs(fs), .fp_enable(fp_enable),
      .wfi_illegal(wfi_illegal), .mstatus(mstatus), .sstatus(sstatus));

   priv_status_unit #(.XLEN(64), .HAS_S(0), .HAS_U(1), .HAS_FS(1), .TW_TIMEOUT(TW)) u_ns (
      .clk(clk), .rst(rst), .csr_write(csr_write), .data_csr(data_csr),
      .mrw_mstatus_sel(mrw_mstatus_sel), .srw_sstatus_sel(srw_sstatus_sel), .valid(valid),
      .m_ret(m_ret), .s_ret(s_ret), .trap_target_m(trap_target_m), .trap_target_s(trap_target_s),
      .fp_write(fp_write), .wfi_exec(wfi_exec), .wfi_wake(wfi_wake),
      .sie(n_sie), .mie(n_mie), .mprv(n_mprv), .sum(n_sum), .mxr(n_mxr), .tvm(n_tvm), .tw(n_tw),
      .tsr(n_tsr), .priv(n_priv), .mod_priv(n_mod_priv), .eff_priv(n_eff_priv), .fs(n_fs),
      .fp_enable(n_fp_enable), .wfi_illegal(n_wfi_illegal), .mstatus(n_mstatus), .sstatus(n_sstatus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic abort_now();
      return wfi_wake | trap_target_m | trap_target_s | ~mst[21];
   endfunction

   task automatic mreset();
      mst = '0;
      mode = 2'b11;
      wpend = 0;
   endtask

   // Expected outputs for the current cycle: mst holds the stored fields in read-view positions
   function automatic exp_t predict(input string tag);
      exp_t e;
      logic [63:0] sd;
      sd = {mst[14:13] == 2'b11, 63'b0};
      e.tag = tag;
      e.ms = mst | sd | 64'h0000_000A_0000_0000;
      e.ss = (mst & SMASK) | sd | 64'h0000_0002_0000_0000;
      e.priv = 4'b0001 << mode;
      e.modp = 4'b0001 << mst[12:11];
      e.effp = mst[17] ? e.modp : e.priv;
      e.fs = mst[14:13];
      e.fpen = mst[14:13] != 2'b00;
      e.ctrl = {mst[1], mst[3], mst[17], mst[18], mst[19], mst[20], mst[21], mst[22]};
      e.wi = wpend && cyc == wdue && !abort_now();
      return e;
   endfunction

   // A pending WFI carries an absolute deadline: TW cycles of waiting after the one that follows it
   task automatic mstep();
      logic [1:0] old;
      if (wpend) begin
         if (abort_now() || cyc == wdue) wpend = 0;
      end else if (valid && wfi_exec && mst[21] && mode != 2'b11) begin
         wpend = 1;
         wdue = cyc + 1 + TW;
      end
      if (trap_target_m) begin
         mst[7] = mst[3]; mst[3] = 0; mst[12:11] = mode; mode = 2'b11;
      end else if (trap_target_s) begin
         mst[5] = mst[1]; mst[1] = 0; mst[8] = mode == 2'b01; mode = 2'b01;
      end else if (valid && m_ret) begin
         mst[3] = mst[7]; mst[7] = 1; mode = mst[12:11]; mst[12:11] = 2'b00;
         if (mode != 2'b11) mst[17] = 0;
      end else if (valid && s_ret) begin
         mst[1] = mst[5]; mst[5] = 1; mode = mst[8] ? 2'b01 : 2'b00; mst[8] = 0; mst[17] = 0;
      end else if (csr_write && mrw_mstatus_sel) begin
         old = mst[12:11];
         mst = data_csr & MMASK;
         if (data_csr[12:11] == 2'b10) mst[12:11] = old;
      end else if (csr_write && srw_sstatus_sel) mst = (mst & ~SMASK) | (data_csr & SMASK);
      else if (valid && fp_write && mst[14:13] != 2'b00) mst[14:13] = 2'b11;
      cyc++;
   endtask

   task automatic tick(input string tag);
      if (!rst) mreset();
      q.push_back(predict(tag));
      @(posedge clk);
      if (!rst) mreset();
      else mstep();
      #1;
   endtask

   task automatic clr();
      {csr_write, mrw_mstatus_sel, srw_sstatus_sel, valid, m_ret, s_ret} = '0;
      {trap_target_m, trap_target_s, fp_write, wfi_exec, wfi_wake} = '0;
      data_csr = '0;
   endtask

   task automatic wr(input logic m, input logic [63:0] d, input string tag);
      clr();
      csr_write = 1;
      mrw_mstatus_sel = m;
      srw_sstatus_sel = !m;
      data_csr = d;
      tick(tag);
   endtask

   task automatic wfi_run(input bit wake, input string tag, output int np, output int at);
      clr();
      valid = 1;
      wfi_exec = 1;
      tick(tag);
      clr();
      np = 0;
      at = 0;
      for (int n = 1; n <= 8; n++) begin
         wfi_wake = wake && n == 2;
         #1;
         if (wfi_illegal) begin
            np++;
            at = n;
         end
         tick(tag);
      end
   endtask

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".mstatus"}, mstatus, e.ms);
            chk({e.tag, ".sstatus"}, sstatus, e.ss);
            chk({e.tag, ".priv"}, priv, e.priv);
            chk({e.tag, ".mod_priv"}, mod_priv, e.modp);
            chk({e.tag, ".eff_priv"}, eff_priv, e.effp);
            chk({e.tag, ".fs"}, fs, e.fs);
            chk({e.tag, ".fp_enable"}, fp_enable, e.fpen);
            chk({e.tag, ".ctrl"}, {sie, mie, mprv, sum, mxr, tvm, tw, tsr}, e.ctrl);
            chk({e.tag, ".wfi_illegal"}, wfi_illegal, e.wi);
         end
      end
   end

   initial begin : drv
      int np, at;
      clr();
      mreset();
      @(posedge clk);
      #1;
      tick("reset");
      chk("rst_priv", priv, 4'b1000);
      chk("rst_mstatus", mstatus, 64'h0000_000A_0000_0000);
      rst = 1;
      wr(1, 64'h0060_18AA, "wr_ms");
      chk("wr_bits", {sie, mie, mpie_bit(mstatus), tw, tsr}, 5'b11111);
      chk("wr_mpp", mod_priv, 4'b1000);
      chk("wr_xl", mstatus[35:32], 4'b1010);
      chk("wr_priv", priv, 4'b1000);
      wr(1, 64'h0060_00AA, "wr_mpp0");
      clr(); valid = 1; m_ret = 1; tick("mret");
      chk("mret_priv", priv, 4'b0001);
      chk("mret_mpp", mod_priv, 4'b0001);
      chk("mret_mpie", mstatus[7], 1);
      chk("mret_mprv", mprv, 0);
      clr(); trap_target_s = 1; tick("trap_s");
      chk("traps_priv", priv, 4'b0010);
      chk("traps_spp_sie", {mstatus[8], sie}, 2'b00);
      wr(1, 64'h0020_0880, "wr_pre_race");
      clr(); trap_target_m = 1; valid = 1; m_ret = 1; tick("race");
      chk("race_priv", priv, 4'b1000);
      chk("race_mpie", mstatus[7], 0);
      chk("race_mpp", mod_priv, 4'b0010);
      wr(1, 64'h2000, "wr_fs1");
      clr(); valid = 1; fp_write = 1; tick("fp_dirty");
      chk("fs_dirty", fs, 2'b11);
      chk("fs_sd", sstatus[63], 1);
      wr(1, 64'h0, "wr_fs0");
      clr(); valid = 1; fp_write = 1; tick("fp_off");
      chk("fs_off", fs, 2'b00);
      chk("fs_fpen", fp_enable, 0);
      wr(1, 64'h0020_0800, "wr_pre_wfi");
      clr(); valid = 1; m_ret = 1; tick("mret_s");
      chk("wfi_priv", priv, 4'b0010);
      wfi_run(0, "wfi", np, at);
      chk("wfi_pulses", np, 1);
      chk("wfi_cycle", at, TW + 1);
      wfi_run(1, "wfi_wake", np, at);
      chk("wake_pulses", np, 0);
      wr(1, 64'h0020_0800, "wr_mpp1");
      wr(1, 64'h0020_1000, "wr_mpp2");
      chk("warl_mpp", mod_priv, 4'b0010);
      wr(0, 64'h2, "wr_ss");
      chk("ss_sie", sie, 1);
      chk("nos_sie", n_sie, 0);
      chk("nos_xl", n_mstatus[35:32], 4'b0010);
      clr(); valid = 1; wfi_exec = 1; tick("wfi_rst");
      clr(); tick("wfi_rst");
      rst = 0;
      #1;
      chk("rst_async_priv", priv, 4'b1000);
      chk("rst_async_wfi", wfi_illegal, 0);
      tick("rst_mid");
      rst = 1;
      repeat (8) tick("post_rst");
      for (int i = 0; i < 3000; i++) begin
         clr();
         rst = $urandom_range(199) != 0;
         valid = $urandom_range(1);
         csr_write = $urandom_range(3) == 0;
         mrw_mstatus_sel = $urandom_range(1);
         srw_sstatus_sel = $urandom_range(1);
         data_csr = {$urandom, $urandom};
         m_ret = $urandom_range(7) == 0;
         s_ret = $urandom_range(7) == 0;
         trap_target_m = $urandom_range(15) == 0;
         trap_target_s = $urandom_range(15) == 0;
         fp_write = $urandom_range(1);
         wfi_exec = $urandom_range(7) == 0;
         wfi_wake = $urandom_range(15) == 0;
         tick("rand");
      end
      clr();
      rst = 1;
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   function automatic logic mpie_bit(input logic [63:0] v);
      return v[7];
   endfunction
endmodule
